// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-style control FSM: state codes,
// instruction decode constants, datapath mux encodings and the control word.
package multicycle_ctrl_pkg;

  localparam logic [3:0] ST_RESET     = 4'd0;
  localparam logic [3:0] ST_FETCH     = 4'd1;
  localparam logic [3:0] ST_DECODE    = 4'd2;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
  localparam logic [3:0] ST_MEM_READ  = 4'd4;
  localparam logic [3:0] ST_LOAD_WB   = 4'd5;
  localparam logic [3:0] ST_MEM_WRITE = 4'd6;
  localparam logic [3:0] ST_R_EXEC    = 4'd7;
  localparam logic [3:0] ST_R_WB      = 4'd8;
  localparam logic [3:0] ST_I_EXEC    = 4'd9;
  localparam logic [3:0] ST_I_WB      = 4'd10;
  localparam logic [3:0] ST_BRANCH    = 4'd11;
  localparam logic [3:0] ST_JUMP      = 4'd12;
  localparam logic [3:0] ST_TRAP      = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALUOP_PASS = 3'b000;
  localparam logic [2:0] ALUOP_ADD  = 3'b001;
  localparam logic [2:0] ALUOP_SUB  = 3'b010;
  localparam logic [2:0] ALUOP_AND  = 3'b011;

  localparam logic [1:0] SRCA_ALUOUT = 2'b00;
  localparam logic [1:0] SRCA_REGA   = 2'b01;
  localparam logic [1:0] SRCA_PC     = 2'b10;
  localparam logic [1:0] SRCA_MDR    = 2'b11;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Last wait-counter value of the three-cycle FETCH and MEM_READ states.
  localparam logic [1:0] WAIT_LAST = 2'd2;

  typedef struct packed {
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  function automatic logic rtype_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

  function automatic logic [2:0] rtype_aluop(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      FN_SUB:  op = ALUOP_SUB;
      FN_AND:  op = ALUOP_AND;
      default: op = ALUOP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction-field inputs and datapath control outputs of the multicycle controller.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic [1:0] ALUSrcAControl;
  logic [1:0] ALUSrcBControl;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWR;
  logic       IRWrite;
  logic       MDRWrite;
  logic       ABWrite;
  logic       ALUOutWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       illegal;
  logic [3:0] state_out;

  modport master (
    input  opcode, funct, zero,
    output ALUSrcAControl, ALUSrcBControl, ALUOp, PCSource,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWR, IRWrite, MDRWrite,
    output ABWrite, ALUOutWrite, RegWrite, RegDst, MemToReg, illegal, state_out
  );

  modport slave (
    output opcode, funct, zero,
    input  ALUSrcAControl, ALUSrcBControl, ALUOp, PCSource,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWR, IRWrite, MDRWrite,
    input  ABWrite, ALUOutWrite, RegWrite, RegDst, MemToReg, illegal, state_out
  );
endinterface

// File: rtl/multicycle_ctrl_mem_wait_cnt.sv
// 2-bit wait counter: synchronous clear has priority, counts up while enabled
// and saturates at the last wait cycle.
module mem_wait_cnt
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (en_i && (cnt_q != WAIT_LAST)) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS subset; controls decode from the
// state register, the wait counter and the R-type ALU op latched in DECODE.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  multicycle_ctrl_if.master   bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [2:0] alu_fn_q;
  logic [2:0] alu_fn_d;
  logic [1:0] wait_cnt;
  logic       cnt_clr;
  logic       cnt_en;
  ctrl_t      ctrl;

  always_comb begin
    state_d  = state_q;
    alu_fn_d = alu_fn_q;
    case (state_q)
      ST_RESET:     state_d = ST_FETCH;
      ST_FETCH:     if (wait_cnt == WAIT_LAST) state_d = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OP_RTYPE: begin
            if (rtype_legal(bus.funct)) begin
              state_d  = ST_R_EXEC;
              alu_fn_d = rtype_aluop(bus.funct);
            end else begin
              state_d = ST_TRAP;
            end
          end
          OP_ADDI:      state_d = ST_I_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR: begin
        case (bus.opcode)
          OP_LW:   state_d = ST_MEM_READ;
          OP_SW:   state_d = ST_MEM_WRITE;
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM_READ:  if (wait_cnt == WAIT_LAST) state_d = ST_LOAD_WB;
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_I_EXEC:    state_d = ST_I_WB;
      ST_LOAD_WB, ST_MEM_WRITE, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP:
                    state_d = ST_FETCH;
      ST_TRAP:      state_d = ST_TRAP;
      default:      state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RESET;
      alu_fn_q <= ALUOP_PASS;
    end else begin
      state_q  <= state_d;
      alu_fn_q <= alu_fn_d;
    end
  end

  // Counter restarts at 0 on the first cycle of every FETCH / MEM_READ visit.
  assign cnt_clr = ((state_d == ST_FETCH)    && (state_q != ST_FETCH)) ||
                   ((state_d == ST_MEM_READ) && (state_q != ST_MEM_READ));
  assign cnt_en  = (state_q == ST_FETCH) || (state_q == ST_MEM_READ);

  mem_wait_cnt u_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cnt_o   (wait_cnt)
  );

  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (wait_cnt == WAIT_LAST) begin
          ctrl.ir_write  = 1'b1;
          ctrl.alu_src_a = SRCA_PC;
          ctrl.alu_src_b = SRCB_FOUR;
          ctrl.alu_op    = ALUOP_ADD;
          ctrl.pc_source = PCSRC_ALU;
          ctrl.pc_write  = 1'b1;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_a     = SRCA_PC;
        ctrl.alu_src_b     = SRCB_IMM_SH2;
        ctrl.alu_op        = ALUOP_ADD;
        ctrl.alu_out_write = 1'b1;
        ctrl.ab_write      = 1'b1;
      end
      ST_MEM_ADDR, ST_I_EXEC: begin
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_IMM;
        ctrl.alu_op        = ALUOP_ADD;
        ctrl.alu_out_write = 1'b1;
      end
      ST_MEM_READ: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b1;
        ctrl.mdr_write = (wait_cnt == WAIT_LAST);
      end
      ST_LOAD_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.i_or_d = 1'b1;
        ctrl.mem_wr = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = alu_fn_q;
        ctrl.alu_out_write = 1'b1;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_I_WB:  ctrl.reg_write = 1'b1;
      ST_BRANCH: begin
        ctrl.alu_src_a     = SRCA_REGA;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      ST_TRAP:  ctrl.illegal = 1'b1;
      default:  ctrl = '0;
    endcase
  end

  assign bus.ALUSrcAControl = ctrl.alu_src_a;
  assign bus.ALUSrcBControl = ctrl.alu_src_b;
  assign bus.ALUOp          = ctrl.alu_op;
  assign bus.PCSource       = ctrl.pc_source;
  assign bus.PCWrite        = ctrl.pc_write;
  assign bus.PCWriteCond    = ctrl.pc_write_cond;
  assign bus.IorD           = ctrl.i_or_d;
  assign bus.MemRead        = ctrl.mem_read;
  assign bus.MemWR          = ctrl.mem_wr;
  assign bus.IRWrite        = ctrl.ir_write;
  assign bus.MDRWrite       = ctrl.mdr_write;
  assign bus.ABWrite        = ctrl.ab_write;
  assign bus.ALUOutWrite    = ctrl.alu_out_write;
  assign bus.RegWrite       = ctrl.reg_write;
  assign bus.RegDst         = ctrl.reg_dst;
  assign bus.MemToReg       = ctrl.mem_to_reg;
  assign bus.illegal        = ctrl.illegal;
  assign bus.state_out      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks every instruction class cycle by
// cycle, plus trap and asynchronous-reset scenarios.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {SrcA, SrcB, ALUOp, PCSource, PCWrite, PCWriteCond, IorD, MemRead, MemWR,
  //  IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite, RegDst, MemToReg, illegal}
  logic [21:0] obs;
  assign obs = {bus.ALUSrcAControl, bus.ALUSrcBControl, bus.ALUOp, bus.PCSource,
                bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWR,
                bus.IRWrite, bus.MDRWrite, bus.ABWrite, bus.ALUOutWrite,
                bus.RegWrite, bus.RegDst, bus.MemToReg, bus.illegal};

  localparam logic [21:0] E_ZERO    = 22'd0;
  localparam logic [21:0] E_F01     = {9'b0,                          13'b0_0_0_1_0_0_0_0_0_0_0_0_0};
  localparam logic [21:0] E_F2      = {2'b10, 2'b01, 3'b001, 2'b00,   13'b1_0_0_1_0_1_0_0_0_0_0_0_0};
  localparam logic [21:0] E_DEC     = {2'b10, 2'b11, 3'b001, 2'b00,   13'b0_0_0_0_0_0_0_1_1_0_0_0_0};
  localparam logic [21:0] E_REX_ADD = {2'b01, 2'b00, 3'b001, 2'b00,   13'b0_0_0_0_0_0_0_0_1_0_0_0_0};
  localparam logic [21:0] E_REX_SUB = {2'b01, 2'b00, 3'b010, 2'b00,   13'b0_0_0_0_0_0_0_0_1_0_0_0_0};
  localparam logic [21:0] E_REX_AND = {2'b01, 2'b00, 3'b011, 2'b00,   13'b0_0_0_0_0_0_0_0_1_0_0_0_0};
  localparam logic [21:0] E_RWB     = {9'b0,                          13'b0_0_0_0_0_0_0_0_0_1_1_0_0};
  localparam logic [21:0] E_IEX     = {2'b01, 2'b10, 3'b001, 2'b00,   13'b0_0_0_0_0_0_0_0_1_0_0_0_0};
  localparam logic [21:0] E_IWB     = {9'b0,                          13'b0_0_0_0_0_0_0_0_0_1_0_0_0};
  localparam logic [21:0] E_MR01    = {9'b0,                          13'b0_0_1_1_0_0_0_0_0_0_0_0_0};
  localparam logic [21:0] E_MR2     = {9'b0,                          13'b0_0_1_1_0_0_1_0_0_0_0_0_0};
  localparam logic [21:0] E_LWB     = {9'b0,                          13'b0_0_0_0_0_0_0_0_0_1_0_1_0};
  localparam logic [21:0] E_MW      = {9'b0,                          13'b0_0_1_0_1_0_0_0_0_0_0_0_0};
  localparam logic [21:0] E_BR      = {2'b01, 2'b00, 3'b010, 2'b01,   13'b0_1_0_0_0_0_0_0_0_0_0_0_0};
  localparam logic [21:0] E_J       = {2'b00, 2'b00, 3'b000, 2'b10,   13'b1_0_0_0_0_0_0_0_0_0_0_0_0};
  localparam logic [21:0] E_TRAP    = {9'b0,                          13'b0_0_0_0_0_0_0_0_0_0_0_0_1};

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] st, input logic [21:0] ex);
    cmp({tag, ".state"}, 32'(bus.state_out), 32'(st));
    cmp({tag, ".ctrl"},  32'(obs),           32'(ex));
  endtask

  task automatic chk(input string tag, input logic [3:0] st, input logic [21:0] ex);
    @(negedge clk);
    check_now(tag, st, ex);
  endtask

  // Garbage opcode/funct during FETCH must not matter; real fields arrive for DECODE.
  task automatic fetch_dec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input string tag);
    bus.opcode = 6'h3F;
    bus.funct  = 6'h3F;
    bus.zero   = ~z;
    chk({tag, ".f0"}, ST_FETCH, E_F01);
    chk({tag, ".f1"}, ST_FETCH, E_F01);
    chk({tag, ".f2"}, ST_FETCH, E_F2);
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    chk({tag, ".dec"}, ST_DECODE, E_DEC);
  endtask

  // Called just after a negedge: asserts reset, checks the immediate effect,
  // releases after a posedge and checks the RESET cycle.
  task automatic do_reset(input string tag);
    #1 reset_n = 1'b0;
    #1 check_now({tag, ".async"}, ST_RESET, E_ZERO);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk({tag, ".rel"}, ST_RESET, E_ZERO);
  endtask

  initial begin
    bus.opcode = OP_RTYPE;
    bus.funct  = FN_ADD;
    bus.zero   = 1'b0;

    #1 reset_n = 1'b0;
    #2 check_now("por", ST_RESET, E_ZERO);
    repeat (2) @(posedge clk);
    check_now("por.held", ST_RESET, E_ZERO);
    #1 reset_n = 1'b1;
    chk("por.rel", ST_RESET, E_ZERO);

    fetch_dec(OP_RTYPE, FN_ADD, 1'b0, "add");
    chk("add.exec", ST_R_EXEC, E_REX_ADD);
    chk("add.wb",   ST_R_WB,   E_RWB);

    fetch_dec(OP_RTYPE, FN_SUB, 1'b0, "sub");
    chk("sub.exec", ST_R_EXEC, E_REX_SUB);
    chk("sub.wb",   ST_R_WB,   E_RWB);

    fetch_dec(OP_RTYPE, FN_AND, 1'b1, "and");
    chk("and.exec", ST_R_EXEC, E_REX_AND);
    chk("and.wb",   ST_R_WB,   E_RWB);

    fetch_dec(OP_ADDI, 6'h00, 1'b0, "addi");
    chk("addi.exec", ST_I_EXEC, E_IEX);
    chk("addi.wb",   ST_I_WB,   E_IWB);

    fetch_dec(OP_LW, 6'h00, 1'b0, "lw");
    chk("lw.addr", ST_MEM_ADDR, E_IEX);
    chk("lw.mr0",  ST_MEM_READ, E_MR01);
    chk("lw.mr1",  ST_MEM_READ, E_MR01);
    chk("lw.mr2",  ST_MEM_READ, E_MR2);
    chk("lw.wb",   ST_LOAD_WB,  E_LWB);

    fetch_dec(OP_SW, 6'h00, 1'b0, "sw");
    chk("sw.addr", ST_MEM_ADDR,  E_IEX);
    chk("sw.wr",   ST_MEM_WRITE, E_MW);

    fetch_dec(OP_BEQ, 6'h00, 1'b0, "beq0");
    chk("beq0.br", ST_BRANCH, E_BR);
    fetch_dec(OP_BEQ, 6'h00, 1'b1, "beq1");
    chk("beq1.br", ST_BRANCH, E_BR);

    fetch_dec(OP_J, 6'h00, 1'b0, "j");
    chk("j.jump", ST_JUMP, E_J);

    // Unsupported funct traps; later opcode changes cannot leave TRAP.
    fetch_dec(OP_RTYPE, 6'h25, 1'b0, "badfn");
    for (int i = 0; i < 12; i++) begin
      chk("badfn.trap", ST_TRAP, E_TRAP);
      bus.opcode = (i % 2 == 0) ? OP_ADDI : OP_J;
      bus.funct  = FN_ADD;
    end
    do_reset("trap_rst");

    fetch_dec(6'h3F, 6'h00, 1'b0, "badop");
    for (int i = 0; i < 12; i++) begin
      chk("badop.trap", ST_TRAP, E_TRAP);
    end
    do_reset("trap_rst2");

    // Reset in the middle of MEM_READ, then a full fetch proves the counter restarted.
    fetch_dec(OP_LW, 6'h00, 1'b0, "lwrst");
    chk("lwrst.addr", ST_MEM_ADDR, E_IEX);
    chk("lwrst.mr0",  ST_MEM_READ, E_MR01);
    chk("lwrst.mr1",  ST_MEM_READ, E_MR01);
    do_reset("mr_rst");
    fetch_dec(OP_J, 6'h00, 1'b0, "post_mr");
    chk("post_mr.jump", ST_JUMP, E_J);

    // Reset in the middle of FETCH.
    chk("mf.f0", ST_FETCH, E_F01);
    chk("mf.f1", ST_FETCH, E_F01);
    do_reset("mf_rst");
    fetch_dec(OP_ADDI, 6'h00, 1'b0, "post_mf");
    chk("post_mf.exec", ST_I_EXEC, E_IEX);
    chk("post_mf.wb",   ST_I_WB,   E_IWB);
    chk("post_mf.next", ST_FETCH,  E_F01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  single clock, all state changes on rising edge.
REQ-002 SHALL expose: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL expose: opcode  in  6  IR[31:26]; funct  in  6  IR[5:0]; zero  in  1  ALU zero flag.
REQ-004 SHALL expose: ALUSrcAControl  out  2  00 ALUOut, 01 RegA, 10 PC, 11 MDR; ALUSrcBControl  out  2  00 RegB, 01 const 4, 10 sext imm, 11 sext imm<<2.
REQ-005 SHALL expose: ALUOp  out  3  000 pass A, 001 add, 010 sub, 011 and.
REQ-006 SHALL expose 1-bit outs: PCWrite, PCWriteCond, IorD, MemRead, MemWR, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite, RegDst (1=rd), MemToReg (1=MDR), illegal.
REQ-007 SHALL expose: PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target; state_out  out  4  current state code.

Function
REQ-008 SHALL be a Moore FSM: all outputs decoded from state register and wait counter only; every output not listed for a state is 0.
REQ-009 States: RESET, FETCH, DECODE, MEM_ADDR, MEM_READ, LOAD_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, TRAP.
REQ-010 RESET: held while reset_n=0; one cycle after release, then FETCH.
REQ-011 FETCH: 3 cycles (counter 0,1,2); MemRead=1, IorD=0 all 3; cycle 2 adds IRWrite=1, ALUSrcA=10, ALUSrcB=01, ALUOp=001, PCSource=00, PCWrite=1; -> DECODE.
REQ-012 DECODE: 1 cycle; ALUSrcA=10, ALUSrcB=11, ALUOp=001, ALUOutWrite=1, ABWrite=1; dispatch on opcode.
REQ-013 Dispatch: 0x00 -> R_EXEC if funct in {0x20,0x22,0x24} else TRAP; 0x08 -> I_EXEC; 0x23/0x2B -> MEM_ADDR; 0x04 -> BRANCH; 0x02 -> JUMP; any other -> TRAP.
REQ-014 R_EXEC: ALUSrcA=01, ALUSrcB=00, ALUOp = 001/010/011 for funct 0x20/0x22/0x24, ALUOutWrite=1; -> R_WB.
REQ-015 R_WB: RegWrite=1, RegDst=1, MemToReg=0; -> FETCH.
REQ-016 I_EXEC: ALUSrcA=01, ALUSrcB=10, ALUOp=001, ALUOutWrite=1; -> I_WB; I_WB: RegWrite=1, RegDst=0, MemToReg=0; -> FETCH.
REQ-017 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=001, ALUOutWrite=1; opcode 0x23 -> MEM_READ, 0x2B -> MEM_WRITE.
REQ-018 MEM_READ: 3 cycles; MemRead=1, IorD=1 all 3; cycle 2 adds MDRWrite=1; -> LOAD_WB.
REQ-019 LOAD_WB: RegWrite=1, RegDst=0, MemToReg=1; -> FETCH.
REQ-020 MEM_WRITE: 1 cycle; IorD=1, MemWR=1; -> FETCH.
REQ-021 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=010, PCWriteCond=1, PCSource=01; -> FETCH; PC update gated by zero in datapath, FSM path independent of zero.
REQ-022 JUMP: PCSource=10, PCWrite=1; -> FETCH.
REQ-023 TRAP: illegal=1, all write enables 0; remains until reset_n=0.
REQ-024 Wait counter SHALL be 2 bits, cleared on entry to FETCH and MEM_READ, increment each cycle in them, never exceed 2.
REQ-025 Instruction latency in cycles: R-type 6, addi 6, lw 9, sw 6, beq 5, j 5.
REQ-026 opcode/funct SHALL be sampled only in DECODE/MEM_ADDR/R_EXEC; changes elsewhere have no effect.

Reset
REQ-027 reset_n=0 SHALL force state RESET, counter 0, all outputs 0 immediately (asynchronous), including mid-FETCH, mid-MEM_READ and TRAP.
REQ-028 No memory or register write enable SHALL assert in the cycle reset releases.

Structure
REQ-029 Shared package SHALL hold state codes, opcode/funct constants, ALUOp codes, ALUSrcA/ALUSrcB/PCSource encodings.
REQ-030 One sub-module, mem_wait_cnt (2-bit saturating wait counter with clear), SHALL be instantiated.

Verification
REQ-031 Reset release, opcode=0x00 funct=0x20 -> FETCH x3, DECODE, R_EXEC ALUOp=001, R_WB RegWrite=1 RegDst=1 at cycle 6.
REQ-032 opcode=0x23 -> MEM_READ 3 cycles IorD=1, MDRWrite only in 3rd, LOAD_WB MemToReg=1 at cycle 9.
REQ-033 opcode=0x04 with zero=0 and zero=1 -> identical state sequence, PCWriteCond=1 in BRANCH, ALUOp=010.
REQ-034 opcode=0x3F, or opcode=0x00 funct=0x25 -> TRAP, illegal=1 held 10+ cycles, no write enables.
REQ-035 reset_n=0 during MEM_READ cycle 1 -> outputs 0 same cycle; after release RESET then FETCH counter 0.
